// File: rtl/rom_reader_pkg.sv
// Shared types and helpers for the ROM frame reader: FSM encoding, buffer sizing
// and the packing of the per-pixel {sof,eol,eof} sideband.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int SB_W   = 3;
  localparam int SB_SOF = 2;
  localparam int SB_EOL = 1;
  localparam int SB_EOF = 0;

  // The FIFO must absorb everything already requested from the ROM when the
  // consumer stalls, plus enough slack to keep full rate with m_ready held high.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Small first-word-fall-through FIFO holding returned ROM words plus sideband.
// DEPTH need not be a power of two, so the pointers wrap explicitly.
module rom_rd_fifo
  import rom_reader_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 27,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire;
  logic             rd_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign wr_fire = wr_en_i && (count_q != CNT_W'(DEPTH));
  assign rd_fire = rd_en_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (wr_fire && !rd_fire) begin
      count_d = count_q + 1'b1;
    end else if (!wr_fire && rd_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the top masks the head whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/rom_frame_reader.sv
// Streams one raster frame from a block ROM as a valid/ready pixel stream.
// Reads are credit-limited so a stalled consumer never causes a lost pixel.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, counters at (0,0)
//   ST_RUN   | issuing ROM reads while credits allow
//   ST_DRAIN | last address issued, emptying pipeline and FIFO
module rom_frame_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  loop_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd_en,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy,
  output logic                  done
);

  localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int CNT_W      = clog2(FIFO_DEPTH + 1);
  localparam int XW         = (IMG_W > 1) ? clog2(IMG_W) : 1;
  localparam int YW         = (IMG_H > 1) ? clog2(IMG_H) : 1;
  localparam int FW         = DATA_WIDTH + SB_W;
  localparam logic [63:0] FRAME_END = 64'(BASE_ADDR) + 64'(IMG_W) * 64'(IMG_H);

  if (FRAME_END > (64'd1 << ADDR_WIDTH)) begin : g_addr_range_chk
    $error("rom_frame_reader: frame does not fit in the ROM address space");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_latency_chk
    $error("rom_frame_reader: RD_LATENCY must be 1 or 2");
  end

  rd_state_e state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0][SB_W-1:0] sb_q;
  logic                  done_q;

  logic             issue;
  logic             x_last, y_last;
  logic [SB_W-1:0]  sb_issue;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_head;
  logic             credit_ok;
  logic             pop;

  assign x_last = (x_q == XW'(IMG_W - 1));
  assign y_last = (y_q == YW'(IMG_H - 1));

  always_comb begin
    sb_issue         = '0;
    sb_issue[SB_SOF] = (x_q == '0) && (y_q == '0);
    sb_issue[SB_EOL] = x_last;
    sb_issue[SB_EOF] = x_last && y_last;
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_q[i]);
    end
  end

  // Pops are deliberately ignored here; counting them would only add a comb path.
  assign credit_ok = ((CNT_W+1)'(inflight) + (CNT_W+1)'(fifo_count)) < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d    = '0;
              addr_d = ADDR_WIDTH'(BASE_ADDR);
              if (!loop_en) state_d = ST_DRAIN;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && (inflight == '0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= ADDR_WIDTH'(BASE_ADDR);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      done_q  <= pop && m_eof;
    end
  end

  // Sideband rides alongside the ROM read so it lands in the FIFO with its pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sb_q  <= '0;
    end else begin
      vld_q[0] <= issue;
      sb_q[0]  <= sb_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        sb_q[i]  <= sb_q[i-1];
      end
    end
  end

  rom_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (vld_q[RD_LATENCY-1]),
    .wr_data_i ({rom_rd_data, sb_q[RD_LATENCY-1]}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign m_data    = m_valid ? fifo_head[FW-1:SB_W] : '0;
  assign m_sof     = m_valid && fifo_head[SB_SOF];
  assign m_eol     = m_valid && fifo_head[SB_EOL];
  assign m_eof     = m_valid && fifo_head[SB_EOF];
  assign rom_addr  = addr_q;
  assign rom_rd_en = issue;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_rom_frame_reader.sv
// Self-checking bench: four reader instances with different geometry/latency,
// checked against a pixel-index reference model of the raster stream.
module tb_rom_frame_reader;

  localparam int NI = 4;
  localparam int PW [NI] = '{4, 4, 16, 1};
  localparam int PH [NI] = '{2, 2, 16, 1};
  localparam int PL [NI] = '{1, 2, 1, 2};
  localparam logic [23:0] ROM_TAG = 24'hC30000;

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] start, loop_en, m_ready;
  wire  [NI-1:0][15:0] rom_addr;
  wire  [NI-1:0] rom_rd_en;
  wire  [NI-1:0][23:0] rom_rd_data;
  wire  [NI-1:0][23:0] m_data;
  wire  [NI-1:0] m_valid, m_sof, m_eol, m_eof, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  rom_frame_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(4), .IMG_H(2), .BASE_ADDR(0), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .loop_en(loop_en[0]), .rom_addr(rom_addr[0]),
    .rom_rd_en(rom_rd_en[0]), .rom_rd_data(rom_rd_data[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_sof(m_sof[0]), .m_eol(m_eol[0]), .m_eof(m_eof[0]), .busy(busy[0]), .done(done[0]));

  rom_frame_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(4), .IMG_H(2), .BASE_ADDR(0), .RD_LATENCY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .loop_en(loop_en[1]), .rom_addr(rom_addr[1]),
    .rom_rd_en(rom_rd_en[1]), .rom_rd_data(rom_rd_data[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_sof(m_sof[1]), .m_eol(m_eol[1]), .m_eof(m_eof[1]), .busy(busy[1]), .done(done[1]));

  rom_frame_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(16), .IMG_H(16), .BASE_ADDR(0), .RD_LATENCY(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .loop_en(loop_en[2]), .rom_addr(rom_addr[2]),
    .rom_rd_en(rom_rd_en[2]), .rom_rd_data(rom_rd_data[2]), .m_data(m_data[2]), .m_valid(m_valid[2]),
    .m_ready(m_ready[2]), .m_sof(m_sof[2]), .m_eol(m_eol[2]), .m_eof(m_eof[2]), .busy(busy[2]), .done(done[2]));

  rom_frame_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(24), .IMG_W(1), .IMG_H(1), .BASE_ADDR(0), .RD_LATENCY(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .loop_en(loop_en[3]), .rom_addr(rom_addr[3]),
    .rom_rd_en(rom_rd_en[3]), .rom_rd_data(rom_rd_data[3]), .m_data(m_data[3]), .m_valid(m_valid[3]),
    .m_ready(m_ready[3]), .m_sof(m_sof[3]), .m_eol(m_eol[3]), .m_eof(m_eof[3]), .busy(busy[3]), .done(done[3]));

  // ROM models: word = tag | address; latency 2 adds an always-loaded output register.
  for (genvar g = 0; g < NI; g++) begin : g_rom
    logic [23:0] s1_q, s2_q;
    always @(posedge clk) begin
      if (rom_rd_en[g]) s1_q <= ROM_TAG | 24'(rom_addr[g]);
      s2_q <= s1_q;
    end
    assign rom_rd_data[g] = (PL[g] == 1) ? s1_q : s2_q;
  end

  // Reference model: the k-th accepted pixel must be raster index k mod W*H.
  int   acc_cnt  [NI];
  int   iss_cnt  [NI];
  int   done_cnt [NI];
  logic hs_eof_q [NI];
  logic hold_q   [NI];
  logic [26:0] hold_val [NI];

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      int p;
      int np;
      logic hs;
      if (!rst_n) begin
        acc_cnt[g]  = 0;
        iss_cnt[g]  = 0;
        done_cnt[g] = 0;
        hs_eof_q[g] = 1'b0;
        hold_q[g]   = 1'b0;
        hold_val[g] = '0;
      end else begin
        check_eq("done_after_eof", done[g], hs_eof_q[g]);
        if (done[g]) done_cnt[g]++;
        if (hold_q[g]) begin
          check_eq("hold_valid", m_valid[g], 1);
          check_eq("hold_data", {m_data[g], m_sof[g], m_eol[g], m_eof[g]}, hold_val[g]);
        end
        if (rom_rd_en[g]) iss_cnt[g]++;
        hs = m_valid[g] && m_ready[g];
        if (hs) begin
          np = PW[g] * PH[g];
          p  = acc_cnt[g] % np;
          check_eq("pix_data", m_data[g], ROM_TAG | 24'(p));
          check_eq("pix_sof", m_sof[g], p == 0);
          check_eq("pix_eol", m_eol[g], (p % PW[g]) == PW[g] - 1);
          check_eq("pix_eof", m_eof[g], p == np - 1);
          acc_cnt[g]++;
        end
        check_eq("outstanding_le_depth", (iss_cnt[g] - acc_cnt[g]) <= PL[g] + 2, 1);
        hs_eof_q[g] = hs && m_eof[g];
        hold_q[g]   = m_valid[g] && !m_ready[g];
        hold_val[g] = {m_data[g], m_sof[g], m_eol[g], m_eof[g]};
      end
    end
  end

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int g);
    check_eq("rst_addr", rom_addr[g], 0);
    check_eq("rst_rd_en", rom_rd_en[g], 0);
    check_eq("rst_valid", m_valid[g], 0);
    check_eq("rst_data", m_data[g], 0);
    check_eq("rst_markers", {m_sof[g], m_eol[g], m_eof[g]}, 0);
    check_eq("rst_busy", busy[g], 0);
    check_eq("rst_done", done[g], 0);
  endtask

  // Single frame with m_ready=1: checks start latency, gap-free output and done/busy.
  task automatic run_frame(input int g);
    int lat;
    int np;
    int waited;
    lat = PL[g];
    np  = PW[g] * PH[g];
    pulse_start(g);
    @(negedge clk);
    check_eq("first_rd_en", rom_rd_en[g], 1);
    check_eq("first_addr", rom_addr[g], 0);
    check_eq("busy_on", busy[g], 1);
    for (int e = 1; e <= lat + np; e++) begin
      @(negedge clk);
      check_eq("valid_timing", m_valid[g], e >= lat + 1);
    end
    @(negedge clk);
    check_eq("done_pulse", done[g], 1);
    waited = 0;
    while (busy[g] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("busy_off", busy[g], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base_acc;
    int base_done;
    int first_v;
    int last_v;
    int vcnt;
    logic seen;

    rst_n   = 1'b0;
    start   = '0;
    loop_en = '0;
    m_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) check_reset_outputs(g);
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame(0);
    run_frame(1);
    run_frame(3);

    // 16x16 frame with random backpressure
    pulse_start(2);
    seen = 1'b0;
    cyc  = 0;
    while (!(seen && !busy[2]) && cyc < 4000) begin
      @(posedge clk); #1 m_ready[2] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done[2]) seen = 1'b1;
      cyc++;
    end
    check_eq("rand_finished", cyc < 4000, 1);
    check_eq("rand_pixel_count", acc_cnt[2], 256);
    m_ready[2] = 1'b1;

    // three looped frames, loop_en dropped after the second done
    base_acc  = acc_cnt[2];
    base_done = done_cnt[2];
    loop_en[2] = 1'b1;
    pulse_start(2);
    cyc = 0; first_v = -1; last_v = -1; vcnt = 0;
    while ((busy[2] || cyc < 2) && cyc < 2000) begin
      @(negedge clk);
      if (m_valid[2]) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        vcnt++;
      end
      if (done_cnt[2] - base_done >= 2) loop_en[2] = 1'b0;
      cyc++;
    end
    repeat (3) @(negedge clk);
    check_eq("loop_finished", cyc < 2000, 1);
    check_eq("loop_pixels", acc_cnt[2] - base_acc, 768);
    check_eq("loop_valid_cycles", vcnt, 768);
    check_eq("loop_no_bubble", last_v - first_v + 1, 768);
    check_eq("loop_done_count", done_cnt[2] - base_done, 3);
    check_eq("loop_idle", busy[2], 0);

    // asynchronous reset while pixel 5 is on the bus
    pulse_start(0);
    cyc = 0;
    while (!(m_valid[0] && m_data[0][15:0] == 16'd5) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reach_pixel5", cyc < 50, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("post_rst_busy", busy[0], 0);
    check_eq("post_rst_rd_en", rom_rd_en[0], 0);
    run_frame(0);

    // start while busy is ignored
    base_acc  = acc_cnt[1];
    base_done = done_cnt[1];
    pulse_start(1);
    repeat (3) @(posedge clk);
    #1 start[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0;
    cyc = 0;
    while (busy[1] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (10) @(negedge clk);
    check_eq("busy_start_idle", busy[1], 0);
    check_eq("busy_start_pixels", acc_cnt[1] - base_acc, 8);
    check_eq("busy_start_dones", done_cnt[1] - base_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
